// File: rtl/eeg_ibuf.sv
// EEG chip input buffer: splits the chip byte stream into a data FIFO (first-word-fall-through)
// and a two-beat command path that writes configuration registers.
module eeg_ibuf #(
    parameter int CHIP_DAT_DW = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int CFG_NUM     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           CHIP_DAT_VLD,
    input  logic                           CHIP_DAT_LST,
    output logic                           CHIP_DAT_RDY,
    input  logic [CHIP_DAT_DW-1:0]         CHIP_DAT_DAT,
    input  logic                           CHIP_DAT_CMD,
    output logic                           IBUF_DAT_VLD,
    output logic                           IBUF_DAT_LST,
    input  logic                           IBUF_DAT_RDY,
    output logic [CHIP_DAT_DW-1:0]         IBUF_DAT_DAT,
    output logic [CFG_NUM*CHIP_DAT_DW-1:0] CFG_DAT,
    output logic                           CFG_UPD,
    output logic                           CMD_ERR
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]          DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0]          PTR_ONE   = AW'(1'b1);
    localparam logic [CW-1:0]          CNT_ONE   = CW'(1'b1);
    localparam logic [CHIP_DAT_DW:0]   CFG_NUM_C = (CHIP_DAT_DW + 1)'(CFG_NUM);

    typedef enum logic [0:0] {
        CMD_IDLE      = 1'b0,
        CMD_WAIT_DATA = 1'b1
    } cmd_state_t;

    logic [CHIP_DAT_DW:0]           mem_r [FIFO_DEPTH];
    logic [AW-1:0]                  wr_ptr_r;
    logic [AW-1:0]                  rd_ptr_r;
    logic [CW-1:0]                  count_r;
    logic [CHIP_DAT_DW-1:0]         addr_r;
    logic [CFG_NUM*CHIP_DAT_DW-1:0] cfg_r;
    logic                           cfg_upd_r;
    logic                           cmd_err_r;
    cmd_state_t                     state_r;
    cmd_state_t                     state_next_s;

    logic beat_acc_s;
    logic cmd_acc_s;
    logic push_s;
    logic pop_s;
    logic addr_ok_s;
    logic addr_ld_s;
    logic cfg_wr_s;
    logic err_set_s;

    assign CHIP_DAT_RDY = (count_r != DEPTH_C);
    assign IBUF_DAT_VLD = (count_r != '0);
    assign {IBUF_DAT_LST, IBUF_DAT_DAT} = mem_r[rd_ptr_r];
    assign CFG_DAT = cfg_r;
    assign CFG_UPD = cfg_upd_r;
    assign CMD_ERR = cmd_err_r;

    assign beat_acc_s = CHIP_DAT_VLD & CHIP_DAT_RDY;
    assign cmd_acc_s  = beat_acc_s & CHIP_DAT_CMD;
    assign push_s     = beat_acc_s & ~CHIP_DAT_CMD;
    assign pop_s      = IBUF_DAT_VLD & IBUF_DAT_RDY;
    assign addr_ok_s  = ({1'b0, addr_r} < CFG_NUM_C);

    // FIFO storage; contents are don't-care until pushed, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {CHIP_DAT_LST, CHIP_DAT_DAT};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Command FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= CMD_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Command FSM next state: any accepted beat ends a pending command
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            CMD_IDLE: begin
                if (cmd_acc_s && !CHIP_DAT_LST) begin
                    state_next_s = CMD_WAIT_DATA;
                end else begin
                    state_next_s = CMD_IDLE;
                end
            end
            CMD_WAIT_DATA: begin
                if (beat_acc_s) begin
                    state_next_s = CMD_IDLE;
                end else begin
                    state_next_s = CMD_WAIT_DATA;
                end
            end
            default: state_next_s = CMD_IDLE;
        endcase
    end

    // Command FSM decode; a data beat arriving mid-command is still pushed but flagged
    always_comb begin
        addr_ld_s = 1'b0;
        cfg_wr_s  = 1'b0;
        err_set_s = 1'b0;
        case (state_r)
            CMD_IDLE: begin
                addr_ld_s = cmd_acc_s & ~CHIP_DAT_LST;
                err_set_s = cmd_acc_s & CHIP_DAT_LST;
            end
            CMD_WAIT_DATA: begin
                cfg_wr_s  = cmd_acc_s & addr_ok_s;
                err_set_s = (cmd_acc_s & ~addr_ok_s) | push_s;
            end
            default: begin
                addr_ld_s = 1'b0;
                cfg_wr_s  = 1'b0;
                err_set_s = 1'b0;
            end
        endcase
    end

    // Address latch, configuration registers, update pulse and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r    <= '0;
            cfg_r     <= '0;
            cfg_upd_r <= 1'b0;
            cmd_err_r <= 1'b0;
        end else begin
            if (addr_ld_s) begin
                addr_r <= CHIP_DAT_DAT;
            end
            for (int k = 0; k < CFG_NUM; k++) begin
                if (cfg_wr_s && (addr_r == CHIP_DAT_DW'(k))) begin
                    cfg_r[k*CHIP_DAT_DW +: CHIP_DAT_DW] <= CHIP_DAT_DAT;
                end
            end
            cfg_upd_r <= cfg_wr_s;
            cmd_err_r <= cmd_err_r | err_set_s;
        end
    end

endmodule

// File: tb/tb_eeg_ibuf.sv
// Directed self-checking bench for eeg_ibuf with default parameters.
module tb_eeg_ibuf;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          chip_vld = 1'b0;
    logic          chip_lst = 1'b0;
    logic          chip_rdy;
    logic [DW-1:0] chip_dat = '0;
    logic          chip_cmd = 1'b0;
    logic          ibuf_vld;
    logic          ibuf_lst;
    logic          ibuf_rdy = 1'b0;
    logic [DW-1:0] ibuf_dat;
    logic [31:0]   cfg_dat;
    logic          cfg_upd;
    logic          cmd_err;

    int checks = 0;
    int errors = 0;

    eeg_ibuf #(.CHIP_DAT_DW(8), .FIFO_DEPTH(8), .CFG_NUM(4)) dut (
        .clk(clk), .rst(rst),
        .CHIP_DAT_VLD(chip_vld), .CHIP_DAT_LST(chip_lst), .CHIP_DAT_RDY(chip_rdy),
        .CHIP_DAT_DAT(chip_dat), .CHIP_DAT_CMD(chip_cmd),
        .IBUF_DAT_VLD(ibuf_vld), .IBUF_DAT_LST(ibuf_lst), .IBUF_DAT_RDY(ibuf_rdy),
        .IBUF_DAT_DAT(ibuf_dat), .CFG_DAT(cfg_dat), .CFG_UPD(cfg_upd), .CMD_ERR(cmd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic cmd, input logic lst, input logic [DW-1:0] dat);
        chip_vld = 1'b1; chip_cmd = cmd; chip_lst = lst; chip_dat = dat;
    endtask

    task automatic idle_in();
        chip_vld = 1'b0; chip_cmd = 1'b0; chip_lst = 1'b0; chip_dat = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_in();
        rst = 1'b1;
        tick();
        checks++; if (ibuf_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", ibuf_vld); end
        checks++; if (chip_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", chip_rdy); end
        checks++; if (cfg_dat !== 32'h0) begin errors++; $display("FAIL reset_cfg: got %h want 0", cfg_dat); end
        checks++; if (cfg_upd !== 1'b0 || cmd_err !== 1'b0) begin errors++; $display("FAIL reset_flags: got upd=%b err=%b want 0 0", cfg_upd, cmd_err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_data_stream();
        logic [DW-1:0] exp_b [3];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        ibuf_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, (i == 2), exp_b[i]);
            if (i == 0) begin
                checks++; if (ibuf_vld !== 1'b0) begin errors++; $display("FAIL stream_pre_vld: got %b want 0", ibuf_vld); end
            end
            tick();
            checks++;
            if (ibuf_vld !== 1'b1 || ibuf_dat !== exp_b[i] || ibuf_lst !== (i == 2)) begin
                errors++;
                $display("FAIL stream_beat%0d: got vld=%b dat=%h lst=%b want 1 %h %b", i, ibuf_vld, ibuf_dat, ibuf_lst, exp_b[i], (i == 2));
            end
        end
        idle_in();
        tick();
        checks++; if (ibuf_vld !== 1'b0) begin errors++; $display("FAIL stream_drained: got %b want 0", ibuf_vld); end
    endtask

    task automatic test_backpressure();
        int in_idx;
        int exp_idx;
        logic acc;
        logic pop;
        ibuf_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 8'h40 + 8'(i));
            checks++; if (chip_rdy !== 1'b1) begin errors++; $display("FAIL fill_rdy%0d: got %b want 1", i, chip_rdy); end
            tick();
        end
        checks++; if (chip_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy: got %b want 0", chip_rdy); end
        checks++; if (ibuf_vld !== 1'b1 || ibuf_dat !== 8'h40) begin errors++; $display("FAIL full_head: got vld=%b dat=%h want 1 40", ibuf_vld, ibuf_dat); end
        drive(1'b0, 1'b0, 8'h48);
        tick();
        checks++; if (chip_rdy !== 1'b0) begin errors++; $display("FAIL full_hold_rdy: got %b want 0", chip_rdy); end
        ibuf_rdy = 1'b1;
        #1;
        checks++; if (chip_rdy !== 1'b0) begin errors++; $display("FAIL full_pop_no_pass: got %b want 0", chip_rdy); end
        in_idx = 8;
        exp_idx = 0;
        for (int cyc = 0; cyc < 40 && exp_idx < 10; cyc++) begin
            acc = chip_vld && chip_rdy;
            pop = ibuf_vld;
            if (pop) begin
                checks++;
                if (ibuf_dat !== 8'h40 + 8'(exp_idx) || ibuf_lst !== (exp_idx == 9)) begin
                    errors++;
                    $display("FAIL drain%0d: got dat=%h lst=%b want %h %b", exp_idx, ibuf_dat, ibuf_lst, 8'h40 + 8'(exp_idx), (exp_idx == 9));
                end
            end
            @(posedge clk); #1;
            if (pop) exp_idx++;
            if (acc) begin
                in_idx++;
                if (in_idx < 10) drive(1'b0, (in_idx == 9), 8'h40 + 8'(in_idx));
                else idle_in();
            end
        end
        checks++; if (exp_idx != 10 || in_idx != 10) begin errors++; $display("FAIL drain_count: got out=%0d in=%0d want 10 10", exp_idx, in_idx); end
        checks++; if (ibuf_vld !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", ibuf_vld); end
    endtask

    task automatic test_cfg_write();
        drive(1'b1, 1'b0, 8'h02);
        tick();
        drive(1'b1, 1'b0, 8'hA5);
        checks++; if (cfg_upd !== 1'b0) begin errors++; $display("FAIL cfg_upd_early: got %b want 0", cfg_upd); end
        tick();
        idle_in();
        checks++; if (cfg_upd !== 1'b1 || cfg_dat !== 32'h00A5_0000) begin errors++; $display("FAIL cfg_write: got upd=%b cfg=%h want 1 00a50000", cfg_upd, cfg_dat); end
        tick();
        checks++; if (cfg_upd !== 1'b0) begin errors++; $display("FAIL cfg_upd_pulse: got %b want 0", cfg_upd); end
        checks++; if (ibuf_vld !== 1'b0 || cmd_err !== 1'b0) begin errors++; $display("FAIL cfg_side: got vld=%b err=%b want 0 0", ibuf_vld, cmd_err); end
    endtask

    task automatic test_bad_addr();
        drive(1'b1, 1'b0, 8'h07);
        tick();
        drive(1'b1, 1'b0, 8'h5A);
        tick();
        idle_in();
        checks++; if (cmd_err !== 1'b1 || cfg_upd !== 1'b0) begin errors++; $display("FAIL bad_addr_flags: got err=%b upd=%b want 1 0", cmd_err, cfg_upd); end
        checks++; if (cfg_dat !== 32'h00A5_0000) begin errors++; $display("FAIL bad_addr_cfg: got %h want 00a50000", cfg_dat); end
        tick();
        checks++; if (cfg_upd !== 1'b0 || ibuf_vld !== 1'b0) begin errors++; $display("FAIL bad_addr_after: got upd=%b vld=%b want 0 0", cfg_upd, ibuf_vld); end
    endtask

    task automatic test_data_in_cmd();
        ibuf_rdy = 1'b1;
        drive(1'b1, 1'b0, 8'h01);
        tick();
        drive(1'b0, 1'b0, 8'h3C);
        tick();
        checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL mid_cmd_err: got %b want 1", cmd_err); end
        checks++; if (ibuf_vld !== 1'b1 || ibuf_dat !== 8'h3C) begin errors++; $display("FAIL mid_cmd_data: got vld=%b dat=%h want 1 3c", ibuf_vld, ibuf_dat); end
        drive(1'b1, 1'b0, 8'h01);
        tick();
        drive(1'b1, 1'b0, 8'h77);
        tick();
        idle_in();
        checks++; if (cfg_dat !== 32'h0000_7700 || cfg_upd !== 1'b1) begin errors++; $display("FAIL mid_cmd_recover: got cfg=%h upd=%b want 00007700 1", cfg_dat, cfg_upd); end
        checks++; if (ibuf_vld !== 1'b0) begin errors++; $display("FAIL mid_cmd_no_fifo: got %b want 0", ibuf_vld); end
        tick();
    endtask

    task automatic test_cmd_lst();
        drive(1'b1, 1'b1, 8'h03);
        tick();
        checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL lst_cmd_err: got %b want 1", cmd_err); end
        drive(1'b1, 1'b0, 8'h03);
        tick();
        drive(1'b1, 1'b1, 8'h42);
        tick();
        idle_in();
        checks++; if (cfg_dat !== 32'h4200_0000 || cfg_upd !== 1'b1) begin errors++; $display("FAIL lst_cmd_write: got cfg=%h upd=%b want 42000000 1", cfg_dat, cfg_upd); end
        tick();
    endtask

    task automatic test_reset_mid();
        ibuf_rdy = 1'b0;
        drive(1'b1, 1'b0, 8'h00);
        tick();
        drive(1'b1, 1'b0, 8'h12);
        tick();
        drive(1'b1, 1'b1, 8'h09);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 8'hC0 + 8'(i));
            tick();
        end
        drive(1'b1, 1'b0, 8'h02);
        tick();
        idle_in();
        checks++; if (ibuf_vld !== 1'b1 || cmd_err !== 1'b1 || cfg_dat !== 32'h0000_0012) begin errors++; $display("FAIL pre_reset: got vld=%b err=%b cfg=%h want 1 1 00000012", ibuf_vld, cmd_err, cfg_dat); end
        rst = 1'b1;
        #1;
        checks++; if (ibuf_vld !== 1'b0 || chip_rdy !== 1'b1) begin errors++; $display("FAIL async_reset_fifo: got vld=%b rdy=%b want 0 1", ibuf_vld, chip_rdy); end
        checks++; if (cfg_dat !== 32'h0 || cmd_err !== 1'b0) begin errors++; $display("FAIL async_reset_cfg: got cfg=%h err=%b want 0 0", cfg_dat, cmd_err); end
        tick();
        rst = 1'b0;
        ibuf_rdy = 1'b1;
        tick();
        drive(1'b0, 1'b0, 8'h9D);
        tick();
        idle_in();
        checks++; if (ibuf_vld !== 1'b1 || ibuf_dat !== 8'h9D) begin errors++; $display("FAIL post_reset_first: got vld=%b dat=%h want 1 9d", ibuf_vld, ibuf_dat); end
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL post_reset_err: got %b want 0", cmd_err); end
        tick();
        checks++; if (ibuf_vld !== 1'b0) begin errors++; $display("FAIL post_reset_empty: got %b want 0", ibuf_vld); end
    endtask

    initial begin
        test_reset();
        test_data_stream();
        test_backpressure();
        test_cfg_write();
        test_bad_addr();
        test_reset();
        test_data_in_cmd();
        test_reset();
        test_cmd_lst();
        test_reset();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eeg_ibuf.md
EEG_IBUF -- requirements
Module: eeg_ibuf

Interface
REQ-001 The block SHALL have parameter CHIP_DAT_DW, default 8, which sets the byte width of the chip input stream.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, which sets the number of data-FIFO entries (power of two, at least 2).
REQ-003 The block SHALL have parameter CFG_NUM, default 4, which sets the number of configuration registers (at most 2^CHIP_DAT_DW).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-006 The block SHALL have port CHIP_DAT_VLD, input, 1 bit: input beat valid.
REQ-007 The block SHALL have port CHIP_DAT_LST, input, 1 bit: last beat of a data frame.
REQ-008 The block SHALL have port CHIP_DAT_RDY, output, 1 bit: input ready.
REQ-009 The block SHALL have port CHIP_DAT_DAT, input, CHIP_DAT_DW bits: input byte.
REQ-010 The block SHALL have port CHIP_DAT_CMD, input, 1 bit: beat is a command byte (1) or a data byte (0).
REQ-011 The block SHALL have port IBUF_DAT_VLD, output, 1 bit: downstream beat valid.
REQ-012 The block SHALL have port IBUF_DAT_LST, output, 1 bit: downstream last flag.
REQ-013 The block SHALL have port IBUF_DAT_RDY, input, 1 bit: downstream ready.
REQ-014 The block SHALL have port IBUF_DAT_DAT, output, CHIP_DAT_DW bits: downstream byte.
REQ-015 The block SHALL have port CFG_DAT, output, CFG_NUM*CHIP_DAT_DW bits: register k occupies bits [k*CHIP_DAT_DW +: CHIP_DAT_DW].
REQ-016 The block SHALL have port CFG_UPD, output, 1 bit: one-cycle pulse after a register write.
REQ-017 The block SHALL have port CMD_ERR, output, 1 bit: sticky command-protocol error flag.

Function
REQ-018 The block SHALL accept an input beat when CHIP_DAT_VLD and CHIP_DAT_RDY are both 1 in the same cycle.
REQ-019 CHIP_DAT_RDY SHALL equal (count != FIFO_DEPTH), combinational from registered count, and SHALL gate command beats and data beats alike.
REQ-020 An accepted beat with CMD=0 SHALL be written into the FIFO as {LST, DAT}.
REQ-021 The FIFO SHALL be first-word-fall-through: IBUF_DAT_VLD = (count != 0), and IBUF_DAT_LST/IBUF_DAT_DAT SHALL present the head entry.
REQ-022 A pop SHALL occur when IBUF_DAT_VLD and IBUF_DAT_RDY are both 1.
REQ-023 Latency from an accepted data beat into an empty FIFO to IBUF_DAT_VLD=1 SHALL be exactly 1 cycle.
REQ-024 A simultaneous push and pop SHALL leave count unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-025 When the FIFO is full and a pop occurs in the same cycle, CHIP_DAT_RDY SHALL remain 0 in that cycle (no pass-through).
REQ-026 The command FSM SHALL have states CMD_IDLE and CMD_WAIT_DATA.
REQ-027 In CMD_IDLE, an accepted CMD=1 beat with LST=0 SHALL latch DAT as the address and move the FSM to CMD_WAIT_DATA.
REQ-028 In CMD_IDLE, an accepted CMD=1 beat with LST=1 SHALL set CMD_ERR and leave the FSM in CMD_IDLE.
REQ-029 In CMD_WAIT_DATA, an accepted CMD=1 beat SHALL return the FSM to CMD_IDLE.
REQ-030 On the REQ-029 beat, if the address is below CFG_NUM, the block SHALL write DAT to cfg[address] and assert CFG_UPD for exactly the next cycle.
REQ-031 On the REQ-029 beat, if the address is CFG_NUM or above, the block SHALL set CMD_ERR, write no register and not pulse CFG_UPD.
REQ-032 The LST bit of a command data beat SHALL be ignored.
REQ-033 In CMD_WAIT_DATA, an accepted CMD=0 beat SHALL set CMD_ERR, return the FSM to CMD_IDLE, and still be pushed into the FIFO.
REQ-034 CFG_DAT SHALL update in the cycle after the write and is registered.
REQ-035 Command beats SHALL never enter the FIFO.
REQ-036 CMD_ERR SHALL be cleared only by rst.

Reset
REQ-037 While rst=1, the block SHALL hold count=0, both FIFO pointers=0, FSM=CMD_IDLE, address latch=0, all cfg registers=0, CFG_UPD=0 and CMD_ERR=0.
REQ-038 While rst=1, outputs SHALL be IBUF_DAT_VLD=0 and CHIP_DAT_RDY=1; IBUF_DAT_DAT and IBUF_DAT_LST SHALL be don't-care while IBUF_DAT_VLD=0.
REQ-039 An assertion of rst mid-frame or mid-command SHALL discard FIFO contents and any pending address; the first beat accepted after deassertion SHALL be treated as new.

Verification
REQ-040 Data beats 0x11, 0x22, 0x33 (LST only on 0x33) with IBUF_DAT_RDY=1 -> the same three bytes appear in order, each 1 cycle later, with LST only on 0x33.
REQ-041 IBUF_DAT_RDY=0 and 10 data beats offered -> 8 beats accepted, CHIP_DAT_RDY=0 after the 8th; then IBUF_DAT_RDY=1 -> beats drain in order, and the 9th and 10th beats are accepted once space frees.
REQ-042 Command beats 0x02 then 0xA5 -> CFG_DAT[23:16]=0xA5, CFG_UPD high for one cycle, no FIFO output, CMD_ERR=0.
REQ-043 Command beats 0x07 then 0x5A with CFG_NUM=4 -> CFG_DAT unchanged, CMD_ERR=1, CFG_UPD stays 0.
REQ-044 Command 0x01 followed by data beat 0x3C -> CMD_ERR=1, 0x3C output downstream, FSM in CMD_IDLE, a following command pair 0x01/0x77 writes cfg[1]=0x77.
REQ-045 rst pulsed with 5 entries in the FIFO and the FSM in CMD_WAIT_DATA -> IBUF_DAT_VLD=0, CFG_DAT=0 and CMD_ERR=0 immediately; a subsequent 0x9D data beat is the first downstream output.
